// File: rtl/fs_pkg.sv
// Shared types and default geometry for the multi-word subtractor.
package fs_pkg;

   // Default chunk width and chunk count; the top module takes these as parameter defaults.
   localparam int FS_N     = 4;
   localparam int FS_WORDS = 4;
   localparam int FS_W     = FS_N * FS_WORDS;

   // Width of a counter that indexes 0..words-1; at least one bit.
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   localparam int FS_IDX_W = idx_width(FS_WORDS);

   // Sequencer states: waiting for operands, walking the chunks, holding the result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : fs_pkg

// File: rtl/fs_para.sv
// Combinational N-bit full subtractor slice: {bar,diff} = a - b - bin.
module fs_para #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic [N-1:0] diff,
   output logic         bar
);

   logic [N:0] res;

   // Zero-extended subtraction: bit N of the result is set exactly when a < b + bin.
   always_comb begin
      res = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
   end

   assign diff = res[N-1:0];
   assign bar  = res[N];

endmodule : fs_para

// File: rtl/fs_multiword.sv
// Multi-precision unsigned subtractor: a - b - bin over N*WORDS bits,
// one N-bit chunk per clock, LSB chunk first, borrow held in a register between chunks.
module fs_multiword
   import fs_pkg::*;
#(
   parameter int N     = FS_N,
   parameter int WORDS = FS_WORDS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic               bin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WORDS-1:0] diff,
   output logic               bar,
   output logic               busy
);

   localparam int W     = N * WORDS;
   localparam int IDX_W = idx_width(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t           state_q,  state_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic [W-1:0]     a_sh_q,   a_sh_d;
   logic [W-1:0]     b_sh_q,   b_sh_d;
   logic             borrow_q, borrow_d;
   logic [W-1:0]     diff_q,   diff_d;
   logic             bar_q,    bar_d;

   logic [N-1:0]     slice_diff;
   logic             slice_bar;

   // The single chunk datapath always looks at the low chunk of the shift registers.
   fs_para #(.N(N)) u_slice (
      .a    (a_sh_q[N-1:0]),
      .b    (b_sh_q[N-1:0]),
      .bin  (borrow_q),
      .diff (slice_diff),
      .bar  (slice_bar)
   );

   // Next-state logic: accept operands, step one chunk per RUN cycle, hold the result until taken.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latches).
      state_d  = state_q;
      idx_d    = idx_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bar_d    = bar_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d  = ST_RUN;
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = bin;
               idx_d    = '0;
               diff_d   = '0;
            end
         end

         ST_RUN: begin
            // Write the slice result into the chunk selected by idx.
            for (int i = 0; i < WORDS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  diff_d[i*N +: N] = slice_diff;
               end
            end
            borrow_d = slice_bar;
            a_sh_d   = a_sh_q >> N;
            b_sh_d   = b_sh_q >> N;
            if (idx_q == LAST_IDX) begin
               // Final chunk: its borrow is the borrow-out of the whole operation; idx stays at its last value.
               bar_d   = slice_bar;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         ST_DONE: begin
            // Completing the result handshake only returns to IDLE; new operands wait for the next cycle.
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that overrides every other event.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values from before this edge.
      if (rst) begin
         // NOTE: every register here is control or small datapath state, so all of it is cleared on reset.
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bar_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bar_q    <= bar_d;
      end
   end

   // Handshake and status flags decode directly from the state register.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign diff      = diff_q;
   assign bar       = bar_q;

endmodule : fs_multiword

// File: tb/tb_fs_multiword.sv
// Self-checking bench for fs_multiword (N=4, WORDS=4) with a result scoreboard.
module tb_fs_multiword;

   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bar;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bar;
   logic         busy;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   fs_multiword #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bar       (bar),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Golden model: 17-bit unsigned a - b - bin.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      logic [W:0] r;
      r = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      return '{diff: r[W-1:0], bar: r[W]};
   endfunction

   // Present one operand set from IDLE at a negedge; returns at the negedge after the accept edge.
   task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin, input exp_t e);
      a        = ta;
      b        = tb_v;
      bin      = tbin;
      in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid is seen at a negedge; n = -1 when the budget runs out.
   task automatic wait_out(input int budget, output int n);
      n = 0;
      while (!out_valid && n < budget) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!out_valid) n = -1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (diff !== '0) begin failures++; $display("FAIL reset_diff got=%h exp=0000", diff); end
      checks++; if (bar !== 1'b0) begin failures++; $display("FAIL reset_bar got=%b exp=0", bar); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va[3]   = '{16'h1234, 16'h0000, 16'h0100};
      logic [W-1:0] vb[3]   = '{16'h0234, 16'h0000, 16'h0001};
      logic         vbin[3] = '{1'b0, 1'b1, 1'b0};
      logic [W-1:0] vd[3]   = '{16'h1000, 16'hFFFF, 16'h00FF};
      logic         vbar[3] = '{1'b0, 1'b1, 1'b0};
      int   n;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         send_op(va[i], vb[i], vbin[i], '{diff: vd[i], bar: vbar[i]});
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dir%0d_busy_run got=%b exp=1", i, busy); end
         wait_out(20, n);
         checks++; if (n != WORDS) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, n, WORDS); end
         if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL dir%0d_scoreboard_empty got=0 exp=1", i);
         end else begin
            e = sb.pop_front();
            checks++; if (diff !== e.diff) begin failures++; $display("FAIL dir%0d_diff got=%h exp=%h", i, diff, e.diff); end
            checks++; if (bar !== e.bar) begin failures++; $display("FAIL dir%0d_bar got=%b exp=%b", i, bar, e.bar); end
         end
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL dir%0d_return_idle got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int   n;
      exp_t e;
      send_op(16'hABCD, 16'h1234, 1'b0, '{diff: 16'h9999, bar: 1'b0});
      wait_out(20, n);
      checks++; if (n != WORDS) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", n, WORDS); end
      for (int i = 0; i < 5; i++) begin
         a        = 16'h0000;
         b        = 16'hFFFF;
         bin      = 1'b1;
         in_valid = (i % 2) == 0;
         @(posedge clk);
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL bp_stall%0d_flags got ov=%b ir=%b busy=%b exp 1/0/1", i, out_valid, in_ready, busy);
         end
         checks++; if (diff !== 16'h9999 || bar !== 1'b0) begin
            failures++; $display("FAIL bp_stall%0d_hold got=%b_%h exp=0_9999", i, bar, diff);
         end
      end
      if (sb.size() == 0) begin
         checks++; failures++; $display("FAIL bp_scoreboard_empty got=0 exp=1");
      end else begin
         e = sb.pop_front();
         checks++; if (diff !== e.diff || bar !== e.bar) begin
            failures++; $display("FAIL bp_result got=%b_%h exp=%b_%h", bar, diff, e.bar, e.diff);
         end
      end
      // Result handshake and new operands in the same cycle: operands must not be taken.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL bp_release got ov=%b ir=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
      end
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept_in_done got busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid_run();
      int   n;
      exp_t e;
      send_op(16'h5555, 16'h1111, 1'b0, '{diff: 16'h4444, bar: 1'b0});
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL rstrun_flags got ir=%b ov=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
      end
      checks++; if (diff !== '0 || bar !== 1'b0) begin
         failures++; $display("FAIL rstrun_result got=%b_%h exp=0_0000", bar, diff);
      end
      send_op(16'hFFFF, 16'h0001, 1'b1, '{diff: 16'hFFFD, bar: 1'b0});
      wait_out(20, n);
      checks++; if (n != WORDS) begin failures++; $display("FAIL rstrun_latency got=%0d exp=%0d", n, WORDS); end
      if (sb.size() != 1) begin
         checks++; failures++; $display("FAIL rstrun_scoreboard_depth got=%0d exp=1", sb.size());
      end else begin
         e = sb.pop_front();
         checks++; if (diff !== e.diff || bar !== e.bar) begin
            failures++; $display("FAIL rstrun_result_after got=%b_%h exp=%b_%h", bar, diff, e.bar, e.diff);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      int   done_cnt = 0;
      int   cyc      = 0;
      exp_t e;
      while (done_cnt < 1000 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = W'($urandom);
         b         = W'($urandom);
         bin       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) sb.push_back(model(a, b, bin));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; failures++; $display("FAIL rand_unexpected_result got=%b_%h", bar, diff);
            end else begin
               e = sb.pop_front();
               checks++; if (diff !== e.diff || bar !== e.bar) begin
                  failures++; $display("FAIL rand%0d got=%b_%h exp=%b_%h", done_cnt, bar, diff, e.bar, e.diff);
               end
            end
            done_cnt++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if (done_cnt < 1000) begin
         failures++; $display("FAIL rand_budget got=%0d results exp=1000", done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fs_multiword
